llki_discrete_master: RTL
=========================

Name: llki_discrete_master

Overview:
- Initiator end of the LLKI discrete key-loading interface.
- Buffers key words written by the host-side command port, then streams them to a core's discrete slave with a valid/ready handshake.
- Issues key-clear requests and reports completion, errors and timeouts as single-cycle responses.
- Sits between the SRoT/host command path and each LLKI-enabled core wrapper.

Parameters:
- KEY_WORDS, 2, depth of the key-word buffer (64-bit words); the maximum number of words sent per load.
- TIMEOUT_CYCLES, 1024, cycles allowed in any wait state before aborting with TIMEOUT.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- cmd_valid  input  1  host command strobe.
- cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid & cmd_ready.
- cmd_op  input  2  command: 00 NOP, 01 WRITE_WORD, 10 LOAD_KEY, 11 CLEAR_KEY.
- cmd_data  input  64  key word for WRITE_WORD; ignored otherwise.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_status  output  3  status: 0 OK, 1 OVERFLOW, 2 EMPTY, 3 TIMEOUT; valid only with rsp_valid.
- key_loaded  output  1  set on successful load; cleared by CLEAR_KEY or reset.
- llkid_key_data  output  64  current key word.
- llkid_key_valid  output  1  key word valid.
- llkid_key_ready  input  1  slave accepts the word when valid & ready.
- llkid_key_complete  input  1  slave indicates the full key has been received.
- llkid_clear_key  output  1  clear request level.
- llkid_clear_key_ack  input  1  slave acknowledges the clear.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0 except cmd_ready. cmd_ready is 0 while rst_n is low and 1 from the first clock after release. Buffer count, pointers and timer are 0. Buffer contents are don't-care. A reset asserted mid-transfer drops llkid_key_valid and llkid_clear_key immediately; no response is issued.
- States:
  - IDLE: cmd_ready=1.
  - SEND: llkid_key_valid=1, llkid_key_data=buf[rd_ptr].
  - WAIT_CMPL
  - CLEAR: llkid_clear_key=1.
  - SCRUB: optional feature only.
- NOP: accepted, no response.
- WRITE_WORD in IDLE:
  - count<KEY_WORDS: store at buf[count], count++, rsp OK on the next cycle.
  - count==KEY_WORDS: data dropped, count unchanged, rsp OVERFLOW.
- LOAD_KEY in IDLE:
  - count==0: rsp EMPTY, stay in IDLE.
  - Otherwise: rd_ptr=0, timer=0, go to SEND next cycle.
- SEND:
  - On valid&ready: rd_ptr++ and timer resets.
  - Data is held stable while ready is low.
  - After the handshake of word count-1, drop valid and go to WAIT_CMPL.
- WAIT_CMPL: when llkid_key_complete=1, set key_loaded, clear count to 0, rsp OK, go to IDLE (or SCRUB if enabled).
- Timer: increments every cycle in SEND, WAIT_CMPL and CLEAR.
  - On reaching TIMEOUT_CYCLES-1 without progress: deassert valid/clear, rsp TIMEOUT, go to IDLE.
  - count is retained after a timeout, so the host can retry LOAD_KEY.
- Simultaneous completion or ack and timeout in the same cycle: completion/ack wins.
- CLEAR_KEY in IDLE:
  - Enter CLEAR; hold llkid_clear_key until llkid_clear_key_ack=1.
  - Then deassert, clear key_loaded and count, rsp OK, return to IDLE.
  - An ack that arrives in the first CLEAR cycle is honoured.
- Latency:
  - WRITE_WORD accepted → rsp in 1 cycle.
  - LOAD_KEY accepted → first llkid_key_valid in 1 cycle.
  - Completion seen → rsp in 1 cycle.
- Responses: exactly one per WRITE_WORD, LOAD_KEY or CLEAR_KEY; none for NOP.
- Stray inputs: llkid_key_complete and llkid_clear_key_ack are ignored outside their wait states.

Optional Feature:
- LLKI_MASTER_KEY_SCRUB_EN defined: after a successful load, enter SCRUB and write zero to each buffer entry, one per cycle, for KEY_WORDS cycles.
  - cmd_ready stays low during SCRUB.
  - The OK response is issued at the end of SCRUB, not at completion.
  - CLEAR_KEY also scrubs before its OK response.
- Undefined: no SCRUB state; buffer contents are left in place and the response timing is as above.

Test Plan:
- WRITE 0xDEADBEEF_00000001, 0x0123_4567_89AB_CDEF, LOAD with ready tied high → two consecutive valid beats with those data, complete asserted 3 cycles later → rsp OK one cycle after; key_loaded=1.
- Three WRITE_WORDs with KEY_WORDS=2 → responses OK, OK, OVERFLOW; LOAD sends only the first two words.
- LOAD with count=0 → rsp EMPTY, llkid_key_valid never asserts.
- TIMEOUT_CYCLES=16, ready held low → valid held 16 cycles with stable data, then dropped; rsp TIMEOUT. Retry with ready high → OK.
- CLEAR_KEY with ack after 5 cycles → clear_key high for exactly 5 cycles, rsp OK, key_loaded=0. Ack and timeout in the same cycle → OK.
- rst_n pulsed low mid-SEND → valid drops asynchronously, no rsp, cmd_ready=1 after release. With LLKI_MASTER_KEY_SCRUB_EN → buffer reads zero after load and OK is delayed by KEY_WORDS cycles.

Source files
------------

// File: rtl/llki_discrete_master.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// llki_discrete_master
//
// Initiator end of the LLKI discrete key-loading interface. Key words written
// on the host command port are buffered, then streamed to a core's discrete
// slave over a valid/ready handshake. Key-clear requests are also issued from
// here. Completion, errors and timeouts are reported as one-cycle responses.
//
// Optional feature (compile-time macro LLKI_MASTER_KEY_SCRUB_EN):
//   When defined, after a successful load or clear the key buffer is
//   overwritten with zeros, one entry per cycle, before the OK response.
//   When undefined, there is no scrub state and the buffer is left in place.
//
// Parameters:
//   KEY_WORDS       depth of the 64-bit key-word buffer / max words per load
//   TIMEOUT_CYCLES  cycles allowed in any wait state before a TIMEOUT abort
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     host command handshake (ready only in IDLE)
//   cmd_op, cmd_data        00 NOP, 01 WRITE_WORD, 10 LOAD_KEY, 11 CLEAR_KEY
//   rsp_valid, rsp_status   one-cycle response: 0 OK, 1 OVERFLOW, 2 EMPTY,
//                           3 TIMEOUT
//   key_loaded              set by a successful load, cleared by CLEAR_KEY
//   llkid_key_data/valid    key word stream towards the slave
//   llkid_key_ready         slave accepts the current word
//   llkid_key_complete      slave has received the whole key
//   llkid_clear_key         clear request level
//   llkid_clear_key_ack     slave acknowledges the clear
// ---------------------------------------------------------------------------
module llki_discrete_master #(
    parameter int KEY_WORDS      = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [63:0] cmd_data,
    output logic        rsp_valid,
    output logic [2:0]  rsp_status,
    output logic        key_loaded,
    output logic [63:0] llkid_key_data,
    output logic        llkid_key_valid,
    input  logic        llkid_key_ready,
    input  logic        llkid_key_complete,
    output logic        llkid_clear_key,
    input  logic        llkid_clear_key_ack
);

    // Index widths; kept at least one bit wide for degenerate parameters.
    localparam int PW = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
    localparam int CW = $clog2(KEY_WORDS + 1);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CW-1:0] KW_C    = CW'(KEY_WORDS);
    localparam logic [TW-1:0] TMO_C   = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [2:0] RSP_OK       = 3'd0;
    localparam logic [2:0] RSP_OVERFLOW = 3'd1;
    localparam logic [2:0] RSP_EMPTY    = 3'd2;
    localparam logic [2:0] RSP_TIMEOUT  = 3'd3;

`ifdef LLKI_MASTER_KEY_SCRUB_EN
    localparam logic [PW-1:0] LAST_PTR_C = PW'(KEY_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_CMPL = 3'd2,
        ST_CLEAR     = 3'd3,
        ST_SCRUB     = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_CMPL = 3'd2,
        ST_CLEAR     = 3'd3
    } state_t;
`endif

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] w_rd_ptr_nxt;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;
    logic          r_key_loaded;
    logic          w_key_loaded_nxt;
    logic          w_rsp_valid_nxt;
    logic [2:0]    w_rsp_status_nxt;
    logic          w_buf_we;
    logic [PW-1:0] w_buf_waddr;
    logic [63:0]   w_buf_wdata;
    logic [63:0]   r_buf [KEY_WORDS];

    logic          r_cmd_ready;
    logic          r_rsp_valid;
    logic [2:0]    r_rsp_status;
    logic [63:0]   r_key_data;
    logic          r_key_valid;
    logic          r_clear_key;

    logic          w_timeout;
    logic          w_last_word;
    logic          w_handshake;

`ifdef LLKI_MASTER_KEY_SCRUB_EN
    logic [PW-1:0] r_scrub_ptr;
    logic [PW-1:0] w_scrub_ptr_nxt;
`endif

    assign w_timeout   = (r_timer == TMO_C);
    assign w_last_word = ((CW'(r_rd_ptr) + CW'(1)) == r_count);
    assign w_handshake = r_key_valid & llkid_key_ready;

    // Next-state, bookkeeping and response decode.
    always_comb begin
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_rd_ptr_nxt     = r_rd_ptr;
        w_timer_nxt      = r_timer;
        w_key_loaded_nxt = r_key_loaded;
        w_rsp_valid_nxt  = 1'b0;
        w_rsp_status_nxt = RSP_OK;
        w_buf_we         = 1'b0;
        w_buf_waddr      = '0;
        w_buf_wdata      = 64'd0;
`ifdef LLKI_MASTER_KEY_SCRUB_EN
        w_scrub_ptr_nxt  = r_scrub_ptr;
`endif

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WRITE: begin
                            w_rsp_valid_nxt = 1'b1;
                            if (r_count < KW_C) begin
                                w_buf_we         = 1'b1;
                                w_buf_waddr      = PW'(r_count);
                                w_buf_wdata      = cmd_data;
                                w_count_nxt      = r_count + CW'(1);
                                w_rsp_status_nxt = RSP_OK;
                            end else begin
                                w_rsp_status_nxt = RSP_OVERFLOW;
                            end
                        end
                        OP_LOAD: begin
                            if (r_count == CW'(0)) begin
                                w_rsp_valid_nxt  = 1'b1;
                                w_rsp_status_nxt = RSP_EMPTY;
                            end else begin
                                w_rd_ptr_nxt = '0;
                                w_timer_nxt  = '0;
                                w_state_nxt  = ST_SEND;
                            end
                        end
                        OP_CLEAR: begin
                            w_timer_nxt = '0;
                            w_state_nxt = ST_CLEAR;
                        end
                        OP_NOP: begin
                            w_state_nxt = ST_IDLE;
                        end
                        default: begin
                            w_state_nxt = ST_IDLE;
                        end
                    endcase
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_SEND: begin
                // Any accepted word counts as progress and restarts the timer.
                if (w_handshake) begin
                    w_timer_nxt = '0;
                    if (w_last_word) begin
                        w_rd_ptr_nxt = '0;
                        w_state_nxt  = ST_WAIT_CMPL;
                    end else begin
                        w_rd_ptr_nxt = r_rd_ptr + PW'(1);
                    end
                end else if (w_timeout) begin
                    w_timer_nxt      = '0;
                    w_state_nxt      = ST_IDLE;
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_status_nxt = RSP_TIMEOUT;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end

            ST_WAIT_CMPL: begin
                // Completion is checked first so it wins over a same-cycle timeout.
                if (llkid_key_complete) begin
                    w_key_loaded_nxt = 1'b1;
                    w_count_nxt      = '0;
                    w_timer_nxt      = '0;
`ifdef LLKI_MASTER_KEY_SCRUB_EN
                    w_scrub_ptr_nxt  = '0;
                    w_state_nxt      = ST_SCRUB;
`else
                    w_state_nxt      = ST_IDLE;
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_status_nxt = RSP_OK;
`endif
                end else if (w_timeout) begin
                    w_timer_nxt      = '0;
                    w_state_nxt      = ST_IDLE;
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_status_nxt = RSP_TIMEOUT;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end

            ST_CLEAR: begin
                // Ack is checked first so it wins over a same-cycle timeout.
                if (llkid_clear_key_ack) begin
                    w_key_loaded_nxt = 1'b0;
                    w_count_nxt      = '0;
                    w_timer_nxt      = '0;
`ifdef LLKI_MASTER_KEY_SCRUB_EN
                    w_scrub_ptr_nxt  = '0;
                    w_state_nxt      = ST_SCRUB;
`else
                    w_state_nxt      = ST_IDLE;
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_status_nxt = RSP_OK;
`endif
                end else if (w_timeout) begin
                    w_timer_nxt      = '0;
                    w_state_nxt      = ST_IDLE;
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_status_nxt = RSP_TIMEOUT;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end

`ifdef LLKI_MASTER_KEY_SCRUB_EN
            ST_SCRUB: begin
                // One zero write per cycle; OK goes out after the last entry.
                w_buf_we    = 1'b1;
                w_buf_waddr = r_scrub_ptr;
                w_buf_wdata = 64'd0;
                if (r_scrub_ptr == LAST_PTR_C) begin
                    w_scrub_ptr_nxt  = '0;
                    w_state_nxt      = ST_IDLE;
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_status_nxt = RSP_OK;
                end else begin
                    w_scrub_ptr_nxt = r_scrub_ptr + PW'(1);
                end
            end
`endif

            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
                w_rd_ptr_nxt = '0;
                w_timer_nxt = '0;
            end
        endcase
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_timer      <= '0;
            r_key_loaded <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_timer      <= w_timer_nxt;
            r_key_loaded <= w_key_loaded_nxt;
        end
    end

`ifdef LLKI_MASTER_KEY_SCRUB_EN
    // Scrub pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scrub_ptr <= '0;
        end else begin
            r_scrub_ptr <= w_scrub_ptr_nxt;
        end
    end
`endif

    // Key-word buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KEY_WORDS; i++) begin
                r_buf[i] <= 64'd0;
            end
        end else if (w_buf_we) begin
            r_buf[w_buf_waddr] <= w_buf_wdata;
        end else begin
            r_buf[w_buf_waddr] <= r_buf[w_buf_waddr];
        end
    end

    // Output registers, decoded from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_status <= 3'd0;
            r_key_valid  <= 1'b0;
            r_key_data   <= 64'd0;
            r_clear_key  <= 1'b0;
        end else begin
            r_cmd_ready  <= (w_state_nxt == ST_IDLE);
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_status <= w_rsp_valid_nxt ? w_rsp_status_nxt : 3'd0;
            r_key_valid  <= (w_state_nxt == ST_SEND);
            // Key data is zero outside SEND so no key material lingers on the bus.
            r_key_data   <= (w_state_nxt == ST_SEND) ? r_buf[w_rd_ptr_nxt] : 64'd0;
            r_clear_key  <= (w_state_nxt == ST_CLEAR);
        end
    end

    assign cmd_ready       = r_cmd_ready;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_status      = r_rsp_status;
    assign key_loaded      = r_key_loaded;
    assign llkid_key_data  = r_key_data;
    assign llkid_key_valid = r_key_valid;
    assign llkid_clear_key = r_clear_key;

endmodule
